fir_band_level_meter: RTL
=========================

# fir_band_level_meter

Per-band level meter that sits directly downstream of each 10-bit fixed-point FIR band filter and consumes its output samples. It converts the sign-magnitude filter output to magnitude, averages it over a fixed window of 2^WIN_LOG2 samples, and tracks the window peak and a clip flag. At each window boundary it publishes average level, peak and threshold status with a one-cycle valid pulse for the band-combining/AGC logic.

## Interface
- WIN_LOG2, 5: log2 of window length N (N = 2^WIN_LOG2); legal 1..8.
- clk  in  1  single clock; FIR output domain, samples qualified by sample_valid.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  fir_in carries a new sample this cycle; may be high on consecutive cycles.
- fir_in  in  10  FIR output, sign-magnitude Q0.9: bit 9 = sign, bits 8:0 = magnitude.
- restart  in  1  synchronous; abandon the current window and start a new one.
- thr  in  9  unsigned level threshold, same scale as the magnitude.
- level  out  10  window average magnitude; bit 9 always 0, so the bus format matches fir_in.
- peak  out  9  largest magnitude in the last completed window.
- clip  out  1  last completed window contained a magnitude of 511.
- above_thr  out  1  level[8:0] > thr, evaluated when the window is published.
- level_valid  out  1  one-cycle pulse; level, peak, clip and above_thr were updated this cycle.

## Operation
- Stage 1 (input register): mag_r = fir_in[8:0], v_r = sample_valid.
  - The sign bit is discarded, so negative zero (10'h200) has magnitude 0.
- Stage 2 (accumulate), on v_r:
  - acc = acc + mag_r; acc is 9+WIN_LOG2 bits wide and never overflows.
  - pk = max(pk, mag_r).
  - clp = clp | (mag_r == 511).
  - cnt = cnt + 1; cnt is WIN_LOG2 bits wide.
- State machine: IDLE -> ACC on the first v_r after reset or restart; ACC -> ACC otherwise.
  - Publish happens inside ACC; there is no dead cycle.
- Publish: the v_r cycle with cnt == N-1 is the last sample of the window. On the next edge:
  - level = {1'b0, (acc + mag_r) >> WIN_LOG2}; truncation, no rounding.
  - peak = max(pk, mag_r).
  - clip = clp | (mag_r == 511).
  - above_thr = (new level[8:0] > thr).
  - level_valid = 1.
  - acc, pk, clp and cnt are cleared in that same edge, so the next sample starts a fresh window.
- Back-to-back windows: a sample arriving on the cycle after a publish is the first sample of the next window. No sample is lost or double-counted.
- restart:
  - Clears acc, pk, clp and cnt, clears the stage-1 v_r, and returns the FSM to IDLE.
  - level, peak, clip and above_thr keep their last published values; no level_valid is generated.
  - restart wins over sample_valid in the same cycle: that sample is discarded.
  - restart in the cycle where a publish would be registered suppresses the publish.
- thr is sampled only at publish. Changing thr between publishes does not alter above_thr.

## Timing
- Reset (rst low, asynchronous):
  - Outputs: level = 0, peak = 0, clip = 0, above_thr = 0, level_valid = 0.
  - Internal: acc, pk, clp, cnt, mag_r and v_r = 0; FSM in IDLE.
- Reset released mid-window: the partial window is lost and counting restarts at the first valid sample after release.
- Latency: the last sample of a window presented with sample_valid at cycle t gives level_valid high at cycle t+2, for exactly one cycle.
- Throughput: one sample per clock. With sample_valid held high, level_valid pulses every N cycles.
- Gaps in sample_valid only stretch the window. A window always contains exactly N samples.
- All outputs are registered and hold their values between level_valid pulses.

## Test plan
- Mixed-sign average, WIN_LOG2=2: fir_in = 10'h20A, 10'h014, 10'h21E, 10'h028 on consecutive cycles, i.e. -10, +20, -30, +40 -> two cycles after the last sample: level = 25, peak = 40, clip = 0, level_valid high for exactly 1 cycle.
- Full scale and clip, WIN_LOG2=2: four samples of 10'h3FF -> level = 511 (sum 2044 >> 2), peak = 511, clip = 1. Next window 0, 0, 0, 10'h200 -> level = 0, peak = 0, clip = 0.
- Continuous stream with gaps, WIN_LOG2=2, thr = 24:
  - Eight samples of magnitude 25 give two level_valid pulses, both with above_thr = 1.
  - Eight samples of magnitude 24 give above_thr = 0.
  - Random sample_valid gaps change only when the pulses occur, never the values.
  - An 8-sample back-to-back stream gives pulses exactly 4 cycles apart.
- restart collision, WIN_LOG2=2: three samples of 100, then restart high together with a fourth sample_valid -> no level_valid; outputs keep their previous values. Four samples of 8 afterwards -> level = 8, peak = 8.
- Async reset mid-window: assert rst low between clock edges after two samples -> all outputs 0 immediately. After release, four samples of 12 -> level = 12 at t+2.
- Truncation, WIN_LOG2=5 default: 32 samples with magnitudes 0..31 (sum 496) -> level = 15, peak = 31, level_valid exactly once.

Source files
------------

// File: rtl/fir_band_level_meter.sv
// Per-band level meter: sign-magnitude FIR samples -> windowed mean magnitude,
// peak and clip, published with a one-cycle valid at each 2^WIN_LOG2-sample boundary.
module fir_band_level_meter #(
   parameter int WIN_LOG2 = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [9:0] fir_in,
   input  logic       restart,
   input  logic [8:0] thr,
   output logic [9:0] level,
   output logic [8:0] peak,
   output logic       clip,
   output logic       above_thr,
   output logic       level_valid
);

   localparam int MAG_W = 9;
   localparam int ACC_W = MAG_W + WIN_LOG2;

   typedef enum logic {IDLE, ACC} state_t;

   state_t              state, state_nxt;
   logic [MAG_W-1:0]    mag_p1;
   logic                vld_p1;
   logic [ACC_W-1:0]    acc_p2;
   logic [MAG_W-1:0]    pk_p2;
   logic                clp_p2;
   logic [WIN_LOG2-1:0] cnt_p2;

   logic                take, publish;
   logic [ACC_W-1:0]    acc_sum;
   logic [MAG_W-1:0]    pk_nxt, lvl_nxt;
   logic                clp_nxt;
   logic                unused_sign;

   // The window sum is always < 512*N, so the shifted mean fits in MAG_W bits.
   function automatic logic [MAG_W-1:0] win_avg(input logic [ACC_W-1:0] sum);
      return MAG_W'(sum >> WIN_LOG2);
   endfunction

   assign unused_sign = fir_in[9];

   always_comb begin
      take      = vld_p1 && !restart;
      publish   = take && (&cnt_p2);
      acc_sum   = acc_p2 + ACC_W'(mag_p1);
      pk_nxt    = (mag_p1 > pk_p2) ? mag_p1 : pk_p2;
      clp_nxt   = clp_p2 | (&mag_p1);
      lvl_nxt   = win_avg(acc_sum);
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ACC;
         ACC:     state_nxt = ACC;
         default: state_nxt = IDLE;
      endcase
      if (restart) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // p1: input register; restart discards the sample arriving with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         mag_p1 <= fir_in[8:0];
         vld_p1 <= sample_valid && !restart;
      end
   end

   // p2: window accumulation; cleared on restart or on the publishing edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_p2 <= '0;
         pk_p2  <= '0;
         clp_p2 <= 1'b0;
         cnt_p2 <= '0;
      end else if (restart || publish) begin
         acc_p2 <= '0;
         pk_p2  <= '0;
         clp_p2 <= 1'b0;
         cnt_p2 <= '0;
      end else if (take) begin
         acc_p2 <= acc_sum;
         pk_p2  <= pk_nxt;
         clp_p2 <= clp_nxt;
         cnt_p2 <= cnt_p2 + WIN_LOG2'(1);
      end
   end

   // Published outputs hold between pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level       <= '0;
         peak        <= '0;
         clip        <= 1'b0;
         above_thr   <= 1'b0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= publish;
         if (publish) begin
            level     <= {1'b0, lvl_nxt};
            peak      <= pk_nxt;
            clip      <= clp_nxt;
            above_thr <= (lvl_nxt > thr);
         end
      end
   end

endmodule
